// File: rtl/serial_write_arbiter.sv
// Round-robin arbiter/sequencer sharing one SerialWriteBuffer between NUM_REQ requesters.
// Optional watchdog abort enabled by defining SERIAL_ARB_TIMEOUT_EN.
module serial_write_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned BUF_SIZE       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned OWNER_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUF_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           done,
    output logic [OWNER_W-1:0]           owner,
    output logic                         active,
    output logic                         buf_start,
    output logic [BUF_SIZE-1:0]          buf_data,
    input  logic                         buf_busy,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUF_SIZE < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("serial_write_arbiter: illegal parameter value");
    end

    state_t               state, state_nx;
    logic [OWNER_W-1:0]   ptr, ptr_nx;
    logic [OWNER_W-1:0]   owner_nx;
    logic [OWNER_W-1:0]   next_ptr;
    logic [BUF_SIZE-1:0]  data_nx;
    logic [NUM_REQ-1:0]   ack_nx, done_nx;
    logic                 active_nx, start_nx;
    logic                 grant_found;
    logic [OWNER_W-1:0]   grant_idx;
    logic [BUF_SIZE-1:0]  grant_data;
    logic [OWNER_W:0]     scan_sum;

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 tmo_nx;
`endif

    // Pointer moves past the requester just served so it becomes lowest priority.
    assign next_ptr = (owner == OWNER_W'(NUM_REQ - 1)) ? '0 : owner + OWNER_W'(1);

    // Round-robin scan starting at ptr, plus the data mux for the winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        scan_sum    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr} + (OWNER_W+1)'(i);
            if (scan_sum >= (OWNER_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (OWNER_W+1)'(NUM_REQ);
            if (!grant_found && req[scan_sum[OWNER_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[OWNER_W-1:0];
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (OWNER_W'(k) == grant_idx)
                grant_data = req_data[k*BUF_SIZE +: BUF_SIZE];
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        owner_nx  = owner;
        data_nx   = buf_data;
        active_nx = active;
        ack_nx    = '0;
        done_nx   = '0;
        start_nx  = 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
        cnt_nx    = cnt;
        tmo_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_found && !buf_busy) begin
                    owner_nx          = grant_idx;
                    data_nx           = grant_data;
                    ack_nx[grant_idx] = 1'b1;
                    active_nx         = 1'b1;
                    state_nx          = START;
                end
            end
            START: begin
                start_nx = 1'b1;
                state_nx = WAIT_BUSY;
`ifdef SERIAL_ARB_TIMEOUT_EN
                cnt_nx   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (buf_busy)
                    state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!buf_busy) begin
                    done_nx[owner] = 1'b1;
                    ptr_nx         = next_ptr;
                    active_nx      = 1'b0;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef SERIAL_ARB_TIMEOUT_EN
        // Watchdog: a normal completion on the same cycle wins over the abort.
        if ((state == WAIT_BUSY || state == WAIT_DONE) && state_nx != IDLE) begin
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_nx    = 1'b1;
                ptr_nx    = next_ptr;
                active_nx = 1'b0;
                state_nx  = IDLE;
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            buf_data    <= '0;
            active      <= 1'b0;
            ack         <= '0;
            done        <= '0;
            buf_start   <= 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            buf_data    <= data_nx;
            active      <= active_nx;
            ack         <= ack_nx;
            done        <= done_nx;
            buf_start   <= start_nx;
`ifdef SERIAL_ARB_TIMEOUT_EN
            cnt         <= cnt_nx;
            timeout_err <= tmo_nx;
`endif
        end
    end

`ifndef SERIAL_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_write_arbiter.sv
// Directed self-checking bench for serial_write_arbiter (NUM_REQ=2, BUF_SIZE=8, TIMEOUT_CYCLES=64).
module tb_serial_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic        buf_busy;
    logic [1:0]  ack, done;
    logic [0:0]  owner;
    logic        active, buf_start, timeout_err;
    logic [7:0]  buf_data;

    int n_vec = 0;
    int n_err = 0;
    int ack_total = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    serial_write_arbiter #(
        .NUM_REQ(2), .BUF_SIZE(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .sys_clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .owner(owner), .active(active),
        .buf_start(buf_start), .buf_data(buf_data), .buf_busy(buf_busy),
        .timeout_err(timeout_err)
    );

    // Pulse counters; sampled at posedge so they see the value held over the previous cycle.
    always @(posedge clk) begin
        ack_total  += $countones(ack);
        done_total += $countones(done);
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_rst;
        rst = 1'b1; req = 2'b00; buf_busy = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 2'b11; buf_busy = 1'b0; req_data = 16'he49c;
        cyc();
        rst = 1'b0; req = 2'b00;
        n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
        n_vec++; if (done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", done); end
        n_vec++; if ({buf_start, active, timeout_err} !== 3'b000) begin n_err++;
            $display("FAIL reset_flags: got %b want 000", {buf_start, active, timeout_err}); end
        n_vec++; if (buf_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", buf_data); end
        n_vec++; if (owner !== 1'b0) begin n_err++; $display("FAIL reset_owner: got %b want 0", owner); end
    endtask

    task automatic test_single;
        do_rst();
        req_data = 16'he49c; req = 2'b01;
        cyc();
        n_vec++; if ({ack, owner, active} !== 4'b01_0_1) begin n_err++;
            $display("FAIL single_ack: got ack/owner/active %b want 0101", {ack, owner, active}); end
        req = 2'b00;
        cyc();
        n_vec++; if ({ack, buf_start} !== 3'b00_1) begin n_err++;
            $display("FAIL single_start: got ack/start %b want 001", {ack, buf_start}); end
        n_vec++; if (buf_data !== 8'h9c) begin n_err++; $display("FAIL single_data: got %h want 9c", buf_data); end
        cyc();
        n_vec++; if (buf_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b want 0", buf_start); end
        buf_busy = 1'b1;
        repeat (40) cyc();
        n_vec++; if ({done, active} !== 3'b00_1) begin n_err++;
            $display("FAIL single_busy: got done/active %b want 001", {done, active}); end
        buf_busy = 1'b0;
        cyc();
        n_vec++; if ({done, active} !== 3'b01_0) begin n_err++;
            $display("FAIL single_done: got done/active %b want 010", {done, active}); end
        cyc();
        n_vec++; if (done !== 2'b00) begin n_err++; $display("FAIL single_done_pulse: got %b want 00", done); end
    endtask

    task automatic test_simultaneous;
        logic [1:0] exp_bits;
        logic [7:0] exp_data;
        do_rst();
        req_data = 16'he49c; req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            exp_bits = (k == 0) ? 2'b01 : 2'b10;
            exp_data = (k == 0) ? 8'h9c : 8'he4;
            cyc();
            n_vec++; if ({ack, owner} !== {exp_bits, 1'(k)}) begin n_err++;
                $display("FAIL simul_ack%0d: got ack/owner %b want %b", k, {ack, owner}, {exp_bits, 1'(k)}); end
            req = (k == 0) ? 2'b10 : 2'b00;
            cyc();
            n_vec++; if ({buf_start, buf_data} !== {1'b1, exp_data}) begin n_err++;
                $display("FAIL simul_data%0d: got start/data %h want %h", k, {buf_start, buf_data}, {1'b1, exp_data}); end
            cyc();
            buf_busy = 1'b1;
            repeat (3) cyc();
            buf_busy = 1'b0;
            cyc();
            n_vec++; if (done !== exp_bits) begin n_err++;
                $display("FAIL simul_done%0d: got %b want %b", k, done, exp_bits); end
        end
    endtask

    task automatic test_rotation;
        int lens [4] = '{2, 7, 80, 3};
        int a0, d0;
        logic [1:0] exp_bits;
        do_rst();
        req_data = 16'he49c; req = 2'b11;
        a0 = ack_total; d0 = done_total;
        for (int t = 0; t < 4; t++) begin
            exp_bits = (t % 2 == 0) ? 2'b01 : 2'b10;
            cyc();
            n_vec++; if (ack !== exp_bits) begin n_err++;
                $display("FAIL rot_ack%0d: got %b want %b", t, ack, exp_bits); end
            cyc();
            n_vec++; if (buf_data !== ((t % 2 == 0) ? 8'h9c : 8'he4)) begin n_err++;
                $display("FAIL rot_data%0d: got %h want %h", t, buf_data, (t % 2 == 0) ? 8'h9c : 8'he4); end
            cyc();
            buf_busy = 1'b1;
            repeat (lens[t]) cyc();
            buf_busy = 1'b0;
            if (t == 3) req = 2'b00;
            cyc();
            n_vec++; if (done !== exp_bits) begin n_err++;
                $display("FAIL rot_done%0d: got %b want %b", t, done, exp_bits); end
        end
        cyc();
        n_vec++; if (ack_total - a0 !== 4) begin n_err++; $display("FAIL rot_ack_count: got %0d want 4", ack_total - a0); end
        n_vec++; if (done_total - d0 !== 4) begin n_err++; $display("FAIL rot_done_count: got %0d want 4", done_total - d0); end
    endtask

    task automatic test_reset_mid;
        int d0;
        do_rst();
        req_data = 16'he49c; req = 2'b01;
        cyc();
        req = 2'b00;
        cyc(); cyc();
        buf_busy = 1'b1; cyc();
        buf_busy = 1'b0; cyc();
        req = 2'b10;
        cyc();
        n_vec++; if (ack !== 2'b10) begin n_err++; $display("FAIL rstmid_ack1: got %b want 10", ack); end
        req = 2'b00;
        cyc(); cyc();
        buf_busy = 1'b1;
        repeat (3) cyc();
        d0 = done_total;
        rst = 1'b1;
        cyc();
        rst = 1'b0; buf_busy = 1'b0; req = 2'b11;
        n_vec++; if ({ack, done, buf_start, active, timeout_err, buf_data, owner} !== 16'h0000) begin n_err++;
            $display("FAIL rstmid_outputs: got %h want 0000", {ack, done, buf_start, active, timeout_err, buf_data, owner}); end
        cyc();
        n_vec++; if ({ack, done} !== 4'b01_00) begin n_err++;
            $display("FAIL rstmid_regrant: got ack/done %b want 0100", {ack, done}); end
        n_vec++; if (done_total !== d0) begin n_err++;
            $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_total - d0); end
        req = 2'b00;
    endtask

    task automatic test_busy_idle;
        do_rst();
        req_data = 16'he49c; buf_busy = 1'b1; req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL busyidle_hold%0d: got %b want 00", i, ack); end
        end
        buf_busy = 1'b0;
        cyc();
        n_vec++; if ({ack, owner} !== 3'b10_1) begin n_err++;
            $display("FAIL busyidle_ack: got ack/owner %b want 101", {ack, owner}); end
        req = 2'b00;
        cyc();
        n_vec++; if ({buf_start, buf_data} !== 9'h1e4) begin n_err++;
            $display("FAIL busyidle_start: got %h want 1e4", {buf_start, buf_data}); end
        cyc();
        buf_busy = 1'b1; cyc(); cyc();
        buf_busy = 1'b0; cyc();
        n_vec++; if (done !== 2'b10) begin n_err++; $display("FAIL busyidle_done: got %b want 10", done); end
    endtask

`ifdef SERIAL_ARB_TIMEOUT_EN
    task automatic test_watchdog;
        do_rst();
        req_data = 16'he49c; req = 2'b11;
        cyc();
        n_vec++; if (ack !== 2'b01) begin n_err++; $display("FAIL wdog_ack0: got %b want 01", ack); end
        cyc();
        buf_busy = 1'b1;
        repeat (63) cyc();
        n_vec++; if ({timeout_err, done, active} !== 4'b0_00_1) begin n_err++;
            $display("FAIL wdog_early: got tmo/done/active %b want 0001", {timeout_err, done, active}); end
        cyc();
        n_vec++; if ({timeout_err, done, active} !== 4'b1_00_0) begin n_err++;
            $display("FAIL wdog_fire: got tmo/done/active %b want 1000", {timeout_err, done, active}); end
        buf_busy = 1'b0;
        cyc();
        n_vec++; if ({ack, timeout_err} !== 3'b10_0) begin n_err++;
            $display("FAIL wdog_next: got ack/tmo %b want 100", {ack, timeout_err}); end
        req = 2'b00;
    endtask
`else
    task automatic test_watchdog;
        do_rst();
        req_data = 16'he49c; req = 2'b01;
        cyc(); req = 2'b00;
        cyc();
        buf_busy = 1'b1;
        repeat (100) cyc();
        n_vec++; if ({timeout_err, done, active} !== 4'b0_00_1) begin n_err++;
            $display("FAIL nowdog_wait: got tmo/done/active %b want 0001", {timeout_err, done, active}); end
        buf_busy = 1'b0;
        cyc();
        n_vec++; if ({done, timeout_err} !== 3'b01_0) begin n_err++;
            $display("FAIL nowdog_done: got done/tmo %b want 010", {done, timeout_err}); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; req = 2'b00; req_data = 16'h0000; buf_busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_rotation();
        test_reset_mid();
        test_busy_idle();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
